// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline constants and fetch FSM state type.
// Imported by the IF stage, its PC pair register and the bench.
package cpu_pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0800_0240;
  localparam int PC_RESET_FRONT = 0;
  localparam int PC_RESET_BACK  = 4;
  localparam int PC_STEP        = 4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    STALL,
    SLOT
  } fetch_state_e;

  function automatic int unsigned word_align(
    input int unsigned a
  );
    return a & ~32'd3;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: hazard/branch control, ROM port and IF/ID outputs.
// master = surrounding pipeline, slave = if_fetch_stage.
interface if_fetch_stage_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
);

  logic               LE;
  logic               br_taken;
  logic [ADDR_W-1:0]  br_target;
  logic               br_nullify;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  pc_out;
  logic               instr_valid;
  logic [CNT_W-1:0]   fetch_cnt;

  modport master (
    output LE,
    output br_taken,
    output br_target,
    output br_nullify,
    output imem_data,
    input  imem_addr,
    input  instr_out,
    input  pc_out,
    input  instr_valid,
    input  fetch_cnt
  );

  modport slave (
    input  LE,
    input  br_taken,
    input  br_target,
    input  br_nullify,
    input  imem_data,
    output imem_addr,
    output instr_out,
    output pc_out,
    output instr_valid,
    output fetch_cnt
  );

endinterface

// File: rtl/if_fetch_stage_pc_pair_reg.sv
// PC front/back pair: sequential step or redirect to a target,
// gated by the pipeline load enable. Synchronous active-high reset.
module pc_pair_reg
  import cpu_pipeline_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_le,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_target,
  output logic [ADDR_W-1:0] o_front,
  output logic [ADDR_W-1:0] o_back
);

  localparam logic [ADDR_W-1:0] STEP =
    ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] r_front;
  logic [ADDR_W-1:0] r_back;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_front <= ADDR_W'(PC_RESET_FRONT);
      r_back  <= ADDR_W'(PC_RESET_BACK);
    end else if (i_le) begin
      if (i_load) begin
        r_front <= i_target;
        r_back  <= i_target + STEP;
      end else begin
        r_front <= r_back;
        r_back  <= r_back + STEP;
      end
    end
  end

  assign o_front = r_front;
  assign o_back  = r_back;

endmodule

// File: rtl/if_fetch_stage.sv
// PA-RISC IF stage: PC pair, ROM address, IF/ID register, delay slot.
// Optional `NULLIFY_EN squashes the delay slot of a ,n taken branch.
module if_fetch_stage
  import cpu_pipeline_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic         Clk,
  input  logic         Rst,
  if_fetch_stage_if.slave bus
);

  localparam logic [ADDR_W-1:0] ALIGN =
    ADDR_W'(word_align(32'hFFFF_FFFF));

  fetch_state_e r_state;
  fetch_state_e w_nxt;

  logic              r_pend_vld;
  logic [ADDR_W-1:0] r_pend_tgt;
  logic              r_pend_nul;

  logic [INSTR_W-1:0] r_instr;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_valid;
  logic [CNT_W-1:0]   r_cnt;

  logic              w_adv;
  logic              w_br;
  logic              w_nul;
  logic              w_squash;
  logic              w_pend_set;
  logic              w_pend_clr;
  logic [ADDR_W-1:0] w_tgt_raw;
  logic [ADDR_W-1:0] w_tgt;
  logic [ADDR_W-1:0] w_front;
  logic [ADDR_W-1:0] w_back;

  // Live branch request always beats a held one.
  always_comb begin
    w_nxt      = r_state;
    w_adv      = 1'b0;
    w_br       = 1'b0;
    w_pend_set = 1'b0;
    w_pend_clr = 1'b0;
    w_tgt_raw  = r_pend_tgt;
    w_nul      = r_pend_nul;
    if (bus.br_taken) begin
      w_tgt_raw = bus.br_target;
      w_nul     = bus.br_nullify;
    end
    unique case (r_state)
      BOOT: begin
        if (bus.LE) begin
          w_adv = 1'b1;
          w_nxt = RUN;
        end
      end
      RUN: begin
        if (bus.LE) begin
          w_adv = 1'b1;
          w_br  = bus.br_taken;
          w_nxt = w_br ? SLOT : RUN;
        end else begin
          w_pend_set = bus.br_taken;
          w_nxt      = STALL;
        end
      end
      STALL: begin
        if (bus.LE) begin
          w_adv      = 1'b1;
          w_pend_clr = 1'b1;
          w_br  = bus.br_taken | r_pend_vld;
          w_nxt = w_br ? SLOT : RUN;
        end else begin
          w_pend_set = bus.br_taken;
        end
      end
      SLOT: begin
        if (bus.LE) begin
          w_adv = 1'b1;
          w_nxt = RUN;
        end
      end
      default: w_nxt = BOOT;
    endcase
  end

  assign w_tgt = w_tgt_raw & ALIGN;

`ifdef NULLIFY_EN
  assign w_squash = w_br & w_nul;
`else
  logic w_unused_nul;
  assign w_squash     = 1'b0;
  assign w_unused_nul = w_nul;
`endif

  pc_pair_reg #(
    .ADDR_W (ADDR_W)
  ) u_pc (
    .i_clk    (Clk),
    .i_rst    (Rst),
    .i_le     (w_adv),
    .i_load   (w_br),
    .i_target (w_tgt),
    .o_front  (w_front),
    .o_back   (w_back)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= BOOT;
      r_pend_vld <= 1'b0;
      r_pend_tgt <= '0;
      r_pend_nul <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_pend_set) begin
        r_pend_vld <= 1'b1;
        r_pend_tgt <= w_tgt;
        r_pend_nul <= w_nul;
      end else if (w_pend_clr) begin
        r_pend_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_instr <= INSTR_W'(NOP_INSTR);
      r_pc    <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (w_adv) begin
      r_pc <= w_front;
      if (w_squash) begin
        r_instr <= INSTR_W'(NOP_INSTR);
        r_valid <= 1'b0;
      end else begin
        r_instr <= bus.imem_data;
        r_valid <= 1'b1;
        r_cnt   <= r_cnt + 1'b1;
      end
    end
  end

  logic [ADDR_W-1:0] w_unused_back;
  assign w_unused_back = w_back;

  assign bus.imem_addr   = w_front;
  assign bus.instr_out   = r_instr;
  assign bus.pc_out      = r_pc;
  assign bus.instr_valid = r_valid;
  assign bus.fetch_cnt   = r_cnt;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed vector bench for if_fetch_stage; ROM[a] = 0xA000 | a.
// Define NULLIFY_EN for both bench and RTL to check delay-slot squash.
module tb_if_fetch_stage;
  import cpu_pipeline_pkg::*;

  typedef struct {
    bit          rst;
    bit          le;
    bit          br;
    bit          nul;
    logic [7:0]  tgt;
    logic [31:0] e_instr;
    logic [7:0]  e_pc;
    bit          e_valid;
    int          e_cnt;
  } vec_t;

`ifdef NULLIFY_EN
  localparam bit NUL = 1'b1;
`else
  localparam bit NUL = 1'b0;
`endif

  logic Clk;
  logic Rst;
  int   n_run;
  int   n_fail;
  vec_t tbl[$];

  if_fetch_stage_if #(
    .ADDR_W (8), .INSTR_W (32), .CNT_W (16)
  ) bus ();

  if_fetch_stage #(
    .ADDR_W (8), .INSTR_W (32), .CNT_W (16)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always_comb bus.imem_data = 32'hA000 | 32'(bus.imem_addr);

  function automatic logic [31:0] rom(input logic [7:0] a);
    return 32'hA000 | 32'(a);
  endfunction

  function automatic vec_t v(
    input bit rst, input bit le, input bit br,
    input bit nul, input logic [7:0] tgt,
    input logic [31:0] ins, input logic [7:0] pc,
    input bit vl, input int cnt
  );
    vec_t r;
    r.rst = rst; r.le = le; r.br = br; r.nul = nul;
    r.tgt = tgt; r.e_instr = ins; r.e_pc = pc;
    r.e_valid = vl; r.e_cnt = cnt;
    return r;
  endfunction

  task automatic chk(
    input string nm, input int idx,
    input logic [31:0] act, input logic [31:0] exp
  );
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h want %h",
               nm, idx, act, exp);
    end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    Rst = 1'b1;
    bus.LE = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_target = '0;
    bus.br_nullify = 1'b0;

    // reset, then straight-line fetch
    tbl.push_back(v(1,1,0,0,0,   NOP_INSTR,  0,0,0));
    tbl.push_back(v(0,1,0,0,0,   rom(0),     0,1,1));
    tbl.push_back(v(0,1,0,0,0,   rom(4),     4,1,2));
    tbl.push_back(v(0,1,0,0,0,   rom(8),     8,1,3));
    // branch 0x40 resolved while IF/ID holds ROM[8]
    tbl.push_back(v(0,1,1,0,8'h40, rom(12),  12,1,4));
    tbl.push_back(v(0,1,1,0,8'h99, rom(8'h40),8'h40,1,5));
    tbl.push_back(v(0,1,0,0,0,   rom(8'h44), 8'h44,1,6));
    // wrap 0xF8..0x04, then unaligned target 0x43
    tbl.push_back(v(0,1,1,0,8'hF8, rom(8'h48),8'h48,1,7));
    tbl.push_back(v(0,1,0,0,0,   rom(8'hF8), 8'hF8,1,8));
    tbl.push_back(v(0,1,0,0,0,   rom(8'hFC), 8'hFC,1,9));
    tbl.push_back(v(0,1,0,0,0,   rom(0),     0,1,10));
    tbl.push_back(v(0,1,1,0,8'h43, rom(4),   4,1,11));
    tbl.push_back(v(0,1,0,0,0,   rom(8'h40), 8'h40,1,12));
    // 3-cycle stall, branch 0x80 held, then resume
    tbl.push_back(v(0,0,0,0,0,   rom(8'h40), 8'h40,1,12));
    tbl.push_back(v(0,0,1,0,8'h80, rom(8'h40),8'h40,1,12));
    tbl.push_back(v(0,0,0,0,0,   rom(8'h40), 8'h40,1,12));
    tbl.push_back(v(0,1,0,0,0,   rom(8'h44), 8'h44,1,13));
    tbl.push_back(v(0,1,0,0,0,   rom(8'h80), 8'h80,1,14));
    tbl.push_back(v(0,1,0,0,0,   rom(8'h84), 8'h84,1,15));
    // plain stall: pending must be gone
    tbl.push_back(v(0,0,0,0,0,   rom(8'h84), 8'h84,1,15));
    tbl.push_back(v(0,1,0,0,0,   rom(8'h88), 8'h88,1,16));
    tbl.push_back(v(0,1,0,0,0,   rom(8'h8C), 8'h8C,1,17));
    // live branch on resume beats pending one
    tbl.push_back(v(0,0,1,0,8'h20, rom(8'h8C),8'h8C,1,17));
    tbl.push_back(v(0,1,1,0,8'h30, rom(8'h90),8'h90,1,18));
    tbl.push_back(v(0,1,0,0,0,   rom(8'h30), 8'h30,1,19));
    // stall while in SLOT
    tbl.push_back(v(0,1,1,0,8'h10, rom(8'h34),8'h34,1,20));
    tbl.push_back(v(0,0,0,0,0,   rom(8'h34), 8'h34,1,20));
    tbl.push_back(v(0,1,0,0,0,   rom(8'h10), 8'h10,1,21));
    // reset in SLOT: target 0x60 never fetched
    tbl.push_back(v(0,1,1,0,8'h60, rom(8'h14),8'h14,1,22));
    tbl.push_back(v(1,1,0,0,0,   NOP_INSTR,  0,0,0));
    tbl.push_back(v(0,1,0,0,0,   rom(0),     0,1,1));
    tbl.push_back(v(0,1,0,0,0,   rom(4),     4,1,2));
    // reset with a pending branch; BOOT holds under LE=0
    tbl.push_back(v(0,0,1,0,8'h70, rom(4),   4,1,2));
    tbl.push_back(v(1,0,0,0,0,   NOP_INSTR,  0,0,0));
    tbl.push_back(v(0,0,0,0,0,   NOP_INSTR,  0,0,0));
    tbl.push_back(v(0,1,0,0,0,   rom(0),     0,1,1));
    tbl.push_back(v(0,1,0,0,0,   rom(4),     4,1,2));
    // ,n branch: slot squashed only with NULLIFY_EN
    tbl.push_back(v(0,1,1,1,8'h20,
      NUL ? NOP_INSTR : rom(8), 8, !NUL, NUL ? 2 : 3));
    tbl.push_back(v(0,1,0,0,0, rom(8'h20), 8'h20, 1,
      NUL ? 3 : 4));

    for (int i = 0; i < tbl.size(); i++) begin
      Rst            = tbl[i].rst;
      bus.LE         = tbl[i].le;
      bus.br_taken   = tbl[i].br;
      bus.br_nullify = tbl[i].nul;
      bus.br_target  = tbl[i].tgt;
      @(posedge Clk);
      #1;
      chk("instr", i, bus.instr_out, tbl[i].e_instr);
      chk("pc", i, 32'(bus.pc_out), 32'(tbl[i].e_pc));
      chk("valid", i, 32'(bus.instr_valid),
          32'(tbl[i].e_valid));
      chk("cnt", i, 32'(bus.fetch_cnt),
          32'(tbl[i].e_cnt));
    end

    // ROM address follows the fetch after the last row
    chk("imem_addr", tbl.size(),
        32'(bus.imem_addr), 32'h24);

    // held stall: outputs stay put over several edges
    Rst = 1'b0;
    bus.LE = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_nullify = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge Clk);
      #1;
      chk("hold_instr", 100 + k,
          bus.instr_out, rom(8'h20));
      chk("hold_addr", 100 + k,
          32'(bus.imem_addr), 32'h24);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
